// File: rtl/cache_pkg.sv
// Shared types and constants for the direct-mapped write-through cache.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MEM_RD = 2'd1,
    MEM_WR = 2'd2,
    RESP   = 2'd3
  } state_t;

  // Default geometry: 16-word Ram, 4 one-word lines.
  localparam int ADDR_BITS_DEF  = 4;
  localparam int INDEX_BITS_DEF = 2;
  localparam int TAG_BITS       = ADDR_BITS_DEF - INDEX_BITS_DEF;
  localparam int LINES          = 1 << INDEX_BITS_DEF;
  localparam int CNT_W          = 16;

  // Statistics counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/cache_controller_if.sv
// CPU-side request/response and Ram-side bus bundled together.
// master = cache controller view, slave = CPU + Ram environment view.
interface cache_controller_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
);
  logic [DEPTH-1:0] cpu_addr;
  logic [WIDTH-1:0] cpu_wdata;
  logic             cpu_read;
  logic             cpu_write;
  logic [WIDTH-1:0] cpu_rdata;
  logic             cpu_ready;
  logic             cpu_busy;

  logic [DEPTH-1:0] mem_adress;
  logic [WIDTH-1:0] mem_data_in;
  logic             mem_write_enable;
  logic             mem_read_enable;
  logic [WIDTH-1:0] mem_data_out;
  logic             mem_valid_out;

  modport master (
    input  cpu_addr, cpu_wdata, cpu_read, cpu_write, mem_data_out, mem_valid_out,
    output cpu_rdata, cpu_ready, cpu_busy,
           mem_adress, mem_data_in, mem_write_enable, mem_read_enable
  );

  modport slave (
    output cpu_addr, cpu_wdata, cpu_read, cpu_write, mem_data_out, mem_valid_out,
    input  cpu_rdata, cpu_ready, cpu_busy,
           mem_adress, mem_data_in, mem_write_enable, mem_read_enable
  );
endinterface

// File: rtl/cache_array.sv
// Line store: valid/tag/data per line, one write port, combinational lookup.
module cache_array import cache_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int TAG_W = TAG_BITS,
  parameter int IDX_W = $clog2(LINES)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [IDX_W+TAG_W-1:0] i_lk_addr,
  output logic                   o_hit,
  output logic [WIDTH-1:0]       o_lk_data,
  input  logic                   i_we,
  input  logic [IDX_W+TAG_W-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]       i_wr_data
);
  localparam int N = 1 << IDX_W;

  logic [N-1:0]            r_valid;
  logic [N-1:0][TAG_W-1:0] r_tag;
  logic [N-1:0][WIDTH-1:0] r_data;

  logic [IDX_W-1:0] w_lk_idx, w_wr_idx;
  logic [TAG_W-1:0] w_lk_tag, w_wr_tag;

  assign {w_lk_tag, w_lk_idx} = i_lk_addr;
  assign {w_wr_tag, w_wr_idx} = i_wr_addr;

  assign o_hit     = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
  assign o_lk_data = r_data[w_lk_idx];

  // Fill or update one line; reset invalidates every line at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid <= '0;
      r_tag   <= '0;
      r_data  <= '0;
    end else if (i_we) begin
      r_valid[w_wr_idx] <= 1'b1;
      r_tag[w_wr_idx]   <= w_wr_tag;
      r_data[w_wr_idx]  <= i_wr_data;
    end
  end
endmodule

// File: rtl/cache_controller.sv
// Direct-mapped, write-through, no-write-allocate cache in front of Ram.
module cache_controller import cache_pkg::*; #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 4,
  parameter int INDEX_BITS = 2
) (
  input  logic             clk,
  input  logic             reset,
  cache_controller_if.master bus,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);
  localparam int TAG_W = DEPTH - INDEX_BITS;

  state_t           r_state, w_next;
  logic [DEPTH-1:0] r_addr;
  logic [WIDTH-1:0] r_wdata;
  logic [WIDTH-1:0] r_rdata;
  logic [CNT_W-1:0] r_hit, r_miss;

  logic             w_idle, w_rd_acc, w_wr_acc;
  logic [DEPTH-1:0] w_lk_addr;
  logic             w_hit;
  logic [WIDTH-1:0] w_lk_data;
  logic             w_arr_we;
  logic [WIDTH-1:0] w_arr_wdata;

  assign w_idle    = (r_state == IDLE);
  // Write wins when both request pulses arrive together.
  assign w_wr_acc  = w_idle && bus.cpu_write;
  assign w_rd_acc  = w_idle && bus.cpu_read && !bus.cpu_write;
  // In IDLE look up the live request; afterwards the latched address.
  assign w_lk_addr = w_idle ? bus.cpu_addr : r_addr;

  cache_array #(.WIDTH(WIDTH), .TAG_W(TAG_W), .IDX_W(INDEX_BITS)) u_array (
    .clk       (clk),
    .reset     (reset),
    .i_lk_addr (w_lk_addr),
    .o_hit     (w_hit),
    .o_lk_data (w_lk_data),
    .i_we      (w_arr_we),
    .i_wr_addr (r_addr),
    .i_wr_data (w_arr_wdata)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next state and line-store write control.
  always_comb begin
    w_next      = r_state;
    w_arr_we    = 1'b0;
    w_arr_wdata = r_wdata;
    case (r_state)
      IDLE: begin
        if (w_wr_acc)      w_next = MEM_WR;
        else if (w_rd_acc) w_next = w_hit ? RESP : MEM_RD;
      end
      MEM_RD: begin
        if (bus.mem_valid_out) begin
          w_next      = RESP;
          w_arr_we    = 1'b1;
          w_arr_wdata = bus.mem_data_out;
        end
      end
      MEM_WR: begin
        w_next   = RESP;
        w_arr_we = w_hit;  // update on hit only, never allocate
      end
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Request latch, read data capture and hit/miss statistics.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_hit   <= '0;
      r_miss  <= '0;
    end else begin
      if (w_wr_acc || w_rd_acc) begin
        r_addr  <= bus.cpu_addr;
        r_wdata <= bus.cpu_wdata;
      end
      if (w_rd_acc && w_hit) begin
        r_rdata <= w_lk_data;
        r_hit   <= sat_inc(r_hit);
      end
      if (w_rd_acc && !w_hit) r_miss <= sat_inc(r_miss);
      if (r_state == MEM_RD && bus.mem_valid_out) r_rdata <= bus.mem_data_out;
    end
  end

  // Everything outward is decoded from registered state only.
  assign bus.cpu_ready        = (r_state == RESP);
  assign bus.cpu_busy         = !w_idle;
  assign bus.cpu_rdata        = (r_state == RESP) ? r_rdata : '0;
  assign bus.mem_read_enable  = (r_state == MEM_RD);
  assign bus.mem_write_enable = (r_state == MEM_WR);
  assign bus.mem_adress       = (r_state == MEM_RD || r_state == MEM_WR) ? r_addr : '0;
  assign bus.mem_data_in      = (r_state == MEM_WR) ? r_wdata : '0;
  assign hit_count            = r_hit;
  assign miss_count           = r_miss;
endmodule

// File: tb/tb_cache_controller.sv
// Bench for cache_controller: behavioural Ram, directed table, corner
// sequences and a randomized run against a spec-level cache model.
module tb_cache_controller;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] hit_count, miss_count;

  cache_controller_if #(.WIDTH(32), .DEPTH(4)) bus();

  cache_controller #(.WIDTH(32), .DEPTH(4), .INDEX_BITS(2)) dut (
    .clk(clk), .reset(reset), .bus(bus), .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Ram: registered read with optional extra wait cycles.
  logic [31:0] ram [16];
  int          ram_lat = 0;
  int          rd_wait = 0;
  always @(posedge clk) begin
    if (bus.mem_write_enable) ram[bus.mem_adress] <= bus.mem_data_in;
    if (bus.mem_read_enable) begin
      rd_wait <= rd_wait + 1;
      if (rd_wait >= ram_lat) begin
        bus.mem_valid_out <= 1'b1;
        bus.mem_data_out  <= ram[bus.mem_adress];
      end else bus.mem_valid_out <= 1'b0;
    end else begin
      rd_wait           <= 0;
      bus.mem_valid_out <= 1'b0;
    end
  end

  // Reference model: what a direct-mapped write-through cache must do.
  logic [31:0] mram [16];
  bit          mv [4];
  int          mt [4];
  logic [31:0] md [4];
  int          mh = 0, mm = 0;

  task automatic model_op(input bit rd, input bit wr, input logic [3:0] a, input logic [31:0] d,
                          input int xl, output int el, output logic [31:0] ed,
                          output int erd, output int ewr);
    int idx, tg;
    bit hit;
    idx = int'(a) % 4;
    tg  = int'(a) / 4;
    hit = mv[idx] && (mt[idx] == tg);
    ed = '0; erd = 0; ewr = 0; el = 0;
    if (wr) begin
      mram[a] = d;
      if (hit) md[idx] = d;
      el = 2; ewr = 1;
    end else if (rd) begin
      if (hit) begin
        ed = md[idx]; el = 1;
        if (mh < 65535) mh++;
      end else begin
        ed = mram[a]; mv[idx] = 1'b1; mt[idx] = tg; md[idx] = ed;
        el = 3 + xl; erd = 2 + xl;
        if (mm < 65535) mm++;
      end
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) mv[i] = 1'b0;
    mh = 0; mm = 0;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h @%0t", nm, act, exp, $time);
    end
  endtask

  // Issue one request pulse and watch the bus until cpu_ready.
  task automatic do_req(input bit rd, input bit wr, input logic [3:0] a, input logic [31:0] d,
                        output int lat, output logic [31:0] rdata, output int rden,
                        output int wren, output logic [3:0] wa, output logic [31:0] wd);
    int n, both;
    bit done;
    lat = -1; rdata = '0; rden = 0; wren = 0; wa = '0; wd = '0; done = 0; both = 0; n = 0;
    @(negedge clk);
    bus.cpu_read = rd; bus.cpu_write = wr; bus.cpu_addr = a; bus.cpu_wdata = d;
    @(posedge clk); #1;
    bus.cpu_read = 1'b0; bus.cpu_write = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    while (!done && n < 60) begin
      @(negedge clk); n++;
      if (bus.mem_read_enable) rden++;
      if (bus.mem_write_enable) begin wren++; wa = bus.mem_adress; wd = bus.mem_data_in; end
      if (bus.mem_read_enable && bus.mem_write_enable) both++;
      if (bus.cpu_ready) begin
        done = 1; lat = n; rdata = bus.cpu_rdata;
        chk("resp_adress_zero", 32'(bus.mem_adress), 32'd0);
        chk("resp_data_in_zero", bus.mem_data_in, 32'd0);
      end
    end
    chk("enables_exclusive", 32'(both), 32'd0);
    if (!done) chk("ready_timeout", 32'(n), 32'd0);
  endtask

  typedef struct {
    bit rd; bit wr; logic [3:0] a; logic [31:0] d;
    int lat; logic [31:0] rdata; int rden; int wren; int hits; int misses;
  } vec_t;
  vec_t tv [10];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, rden, wren, el, erd, ewr, cnt_rdy, cnt_wr;
    logic [31:0] rdata, wd, ed;
    logic [3:0]  wa;
    bit rd, wr;
    logic [3:0]  a;
    logic [31:0] d;

    for (int i = 0; i < 16; i++) begin
      ram[i]  = 32'h5000_0000 + 32'(i);
      mram[i] = 32'h5000_0000 + 32'(i);
    end
    model_reset();
    bus.cpu_read = 1'b0; bus.cpu_write = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.mem_valid_out = 1'b0; bus.mem_data_out = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(bus.cpu_ready), 32'd0);
    chk("rst_busy", 32'(bus.cpu_busy), 32'd0);
    chk("rst_rdata", bus.cpu_rdata, 32'd0);
    chk("rst_enables", 32'({bus.mem_read_enable, bus.mem_write_enable}), 32'd0);
    chk("rst_adress", 32'(bus.mem_adress), 32'd0);
    chk("rst_counts", {hit_count, miss_count}, 32'd0);
    reset = 1'b1;

    // Directed table
    tv[0] = '{1'b0, 1'b1, 4'd2, 32'h0000_AAAA, 2, 32'h0,          0, 1, 0, 0};
    tv[1] = '{1'b1, 1'b0, 4'd2, 32'h0,         3, 32'h0000_AAAA,  2, 0, 0, 1};
    tv[2] = '{1'b1, 1'b0, 4'd2, 32'h0,         1, 32'h0000_AAAA,  0, 0, 1, 1};
    tv[3] = '{1'b0, 1'b1, 4'd6, 32'h0000_BBBB, 2, 32'h0,          0, 1, 1, 1};
    tv[4] = '{1'b1, 1'b0, 4'd6, 32'h0,         3, 32'h0000_BBBB,  2, 0, 1, 2};
    tv[5] = '{1'b1, 1'b0, 4'd2, 32'h0,         3, 32'h0000_AAAA,  2, 0, 1, 3};
    tv[6] = '{1'b0, 1'b1, 4'd2, 32'h0000_1234, 2, 32'h0,          0, 1, 1, 3};
    tv[7] = '{1'b1, 1'b0, 4'd2, 32'h0,         1, 32'h0000_1234,  0, 0, 2, 3};
    tv[8] = '{1'b1, 1'b1, 4'd3, 32'h0000_CCCC, 2, 32'h0,          0, 1, 2, 3};
    tv[9] = '{1'b1, 1'b0, 4'd3, 32'h0,         3, 32'h0000_CCCC,  2, 0, 2, 4};
    ram_lat = 0;
    for (int i = 0; i < 10; i++) begin
      do_req(tv[i].rd, tv[i].wr, tv[i].a, tv[i].d, lat, rdata, rden, wren, wa, wd);
      model_op(tv[i].rd, tv[i].wr, tv[i].a, tv[i].d, 0, el, ed, erd, ewr);
      chk($sformatf("tv%0d_latency", i), 32'(lat), 32'(tv[i].lat));
      chk($sformatf("tv%0d_rden_cycles", i), 32'(rden), 32'(tv[i].rden));
      chk($sformatf("tv%0d_wren_cycles", i), 32'(wren), 32'(tv[i].wren));
      chk($sformatf("tv%0d_hit_count", i), 32'(hit_count), 32'(tv[i].hits));
      chk($sformatf("tv%0d_miss_count", i), 32'(miss_count), 32'(tv[i].misses));
      if (tv[i].wr) begin
        chk($sformatf("tv%0d_wr_adress", i), 32'(wa), 32'(tv[i].a));
        chk($sformatf("tv%0d_wr_data", i), wd, tv[i].d);
      end else
        chk($sformatf("tv%0d_rdata", i), rdata, tv[i].rdata);
    end
    chk("ram_addr3_only_write", ram[3], 32'h0000_CCCC);

    // Requests pulsed while busy are ignored
    ram_lat = 1;
    @(negedge clk);
    bus.cpu_read = 1'b1; bus.cpu_addr = 4'd9;
    @(posedge clk); #1;
    bus.cpu_read = 1'b0; bus.cpu_addr = '0;
    @(negedge clk);
    chk("busy_during_miss", 32'(bus.cpu_busy), 32'd1);
    bus.cpu_write = 1'b1; bus.cpu_read = 1'b1; bus.cpu_addr = 4'd9; bus.cpu_wdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    bus.cpu_write = 1'b0; bus.cpu_read = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    cnt_rdy = 0; cnt_wr = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.cpu_ready) cnt_rdy++;
      if (bus.mem_write_enable) cnt_wr++;
    end
    model_op(1'b1, 1'b0, 4'd9, 32'h0, 1, el, ed, erd, ewr);
    chk("busy_single_ready", 32'(cnt_rdy), 32'd1);
    chk("busy_no_write", 32'(cnt_wr), 32'd0);
    chk("busy_miss_count", 32'(miss_count), 32'(mm));
    do_req(1'b1, 1'b0, 4'd9, 32'h0, lat, rdata, rden, wren, wa, wd);
    model_op(1'b1, 1'b0, 4'd9, 32'h0, 1, el, ed, erd, ewr);
    chk("busy_reread_latency", 32'(lat), 32'(el));
    chk("busy_reread_data", rdata, ed);

    // Reset asserted in the middle of a miss
    ram_lat = 2;
    @(negedge clk);
    bus.cpu_read = 1'b1; bus.cpu_addr = 4'd11;
    @(posedge clk); #1;
    bus.cpu_read = 1'b0; bus.cpu_addr = '0;
    @(negedge clk);
    chk("pre_reset_rden", 32'(bus.mem_read_enable), 32'd1);
    #1 reset = 1'b0;
    #1;
    chk("midrst_rden", 32'(bus.mem_read_enable), 32'd0);
    chk("midrst_wren", 32'(bus.mem_write_enable), 32'd0);
    chk("midrst_ready", 32'(bus.cpu_ready), 32'd0);
    chk("midrst_busy", 32'(bus.cpu_busy), 32'd0);
    chk("midrst_counts", {hit_count, miss_count}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    cnt_rdy = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (bus.cpu_ready) cnt_rdy++;
    end
    chk("midrst_no_ready", 32'(cnt_rdy), 32'd0);
    ram_lat = 0;
    do_req(1'b1, 1'b0, 4'd3, 32'h0, lat, rdata, rden, wren, wa, wd);
    model_op(1'b1, 1'b0, 4'd3, 32'h0, 0, el, ed, erd, ewr);
    chk("postrst_latency", 32'(lat), 32'd3);
    chk("postrst_data", rdata, 32'h0000_CCCC);
    chk("postrst_miss_count", 32'(miss_count), 32'd1);

    // Randomized traffic against the model
    for (int i = 0; i < 250; i++) begin
      int op;
      op = int'($urandom_range(0, 3));
      rd = (op != 2);
      wr = (op >= 2);
      a  = 4'($urandom_range(0, 15));
      d  = $urandom;
      ram_lat = int'($urandom_range(0, 2));
      do_req(rd, wr, a, d, lat, rdata, rden, wren, wa, wd);
      model_op(rd, wr, a, d, ram_lat, el, ed, erd, ewr);
      chk($sformatf("rnd%0d_latency", i), 32'(lat), 32'(el));
      chk($sformatf("rnd%0d_rden", i), 32'(rden), 32'(erd));
      chk($sformatf("rnd%0d_wren", i), 32'(wren), 32'(ewr));
      chk($sformatf("rnd%0d_hits", i), 32'(hit_count), 32'(mh));
      chk($sformatf("rnd%0d_misses", i), 32'(miss_count), 32'(mm));
      if (wr) begin
        chk($sformatf("rnd%0d_wr_adress", i), 32'(wa), 32'(a));
        chk($sformatf("rnd%0d_wr_data", i), wd, d);
      end else
        chk($sformatf("rnd%0d_rdata", i), rdata, ed);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/cache_controller.md
# cache_controller

Direct-mapped, write-through, no-write-allocate cache sitting between the CPU and the `Ram` main-memory block; it serves CPU reads from a small line store and forwards misses and all writes to `Ram` over its `adress`/`data_in`/`write_enable`/`read_enable` and `data_out`/`valid_out` port set. It is the stage directly upstream of `Ram` and its only master. Hit/miss statistics are kept for performance checks.

## Interface
- `WIDTH`, 32: data word width; must match `Ram` `WIDTH`.
- `DEPTH`, 4: address bits; must match `Ram` `DEPTH` (16 words).
- `INDEX_BITS`, 2: line-index bits (4 lines, one word per line); tag = `DEPTH-INDEX_BITS` bits.
- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: asynchronous, active-low; clears all state immediately.
- `cpu_addr` in DEPTH: request word address.
- `cpu_wdata` in WIDTH: write data.
- `cpu_read` in 1: one-cycle read request pulse.
- `cpu_write` in 1: one-cycle write request pulse.
- `cpu_rdata` out WIDTH: read data, valid while `cpu_ready`=1.
- `cpu_ready` out 1: one-cycle completion pulse.
- `cpu_busy` out 1: high whenever state ≠ IDLE; requests ignored.
- `mem_adress` out DEPTH: to `Ram.adress`.
- `mem_data_in` out WIDTH: to `Ram.data_in`.
- `mem_write_enable` out 1: to `Ram.write_enable`.
- `mem_read_enable` out 1: to `Ram.read_enable`.
- `mem_data_out` in WIDTH: from `Ram.data_out`.
- `mem_valid_out` in 1: from `Ram.valid_out`.
- `hit_count`, `miss_count` out 16: saturating read hit/miss counters.

## Operation
- Address split: index = `cpu_addr[INDEX_BITS-1:0]`, tag = upper bits. Hit = line valid AND stored tag equal.
- Request accepted only in IDLE; addr/data/type latched on that edge. `cpu_write` and `cpu_read` both high: write served, read dropped.
- FSM states: IDLE, MEM_RD, MEM_WR, RESP.
  - IDLE: read hit → RESP (data latched from line, `hit_count`+1); read miss → MEM_RD (`miss_count`+1); write → MEM_WR.
  - MEM_RD: `mem_read_enable`=1, `mem_adress`=latched addr; stay until `mem_valid_out` sampled 1, then fill line (data, tag, valid=1), latch data to `cpu_rdata`, → RESP.
  - MEM_WR: `mem_write_enable`=1 for exactly one cycle with latched addr/data; on hit the line data is updated on the same edge (no allocate on miss) → RESP.
  - RESP: `cpu_ready`=1 one cycle → IDLE.
- Memory-side outputs decoded from registered state only; `mem_*` enables never both high. Address/data held 0 in IDLE and RESP.
- Counters saturate at 16'hFFFF; writes do not count.

## Timing
- Read hit: request at edge 0 → `cpu_ready` cycle 1. Latency 1.
- Read miss: edge 0 → MEM_RD cycle 1; `Ram` raises `valid_out` after edge 1; captured edge 2 → `cpu_ready` cycle 3. Latency 3 (longer if `mem_valid_out` late; no timeout).
- Write: edge 0 → MEM_WR cycle 1 → `cpu_ready` cycle 2. Latency 2.
- Next request may be issued in the cycle after `cpu_ready` (IDLE).
- Reset values: all outputs 0, state IDLE, all valid bits 0, counters 0. Reset mid-MEM_RD/MEM_WR drops enables immediately; no line fill, no `cpu_ready`; `Ram` contents untouched.
- Back-to-back read of the same address after a miss is a hit.

## Structure
- Package `cache_pkg`: state enum (IDLE, MEM_RD, MEM_WR, RESP), derived widths (`TAG_BITS`, `LINES`), counter width constant.
- Sub-module `cache_array`: valid/tag/data storage with async-clear valid bits, one write port, combinational lookup returning hit and data.

## Test plan
- Reset, write 32'hAAAA to addr 2 → `mem_write_enable` one cycle with `mem_adress`=2, `cpu_ready` at cycle 2, `miss_count`=0, `hit_count`=0.
- Read addr 2 after the write → miss: `mem_read_enable` high two cycles, `cpu_rdata`=32'hAAAA with `cpu_ready` at cycle 3, `miss_count`=1; repeat read → hit in 1 cycle, no `mem_read_enable`, `hit_count`=1.
- Conflict: write 32'hBBBB to addr 6 (same index as 2), read 6 → miss, BBBB; read 2 → miss, AAAA; `miss_count`=3.
- Write-hit update: with addr 2 cached, write 32'h1234 to 2 → RAM written and line updated; read 2 → hit returning 32'h1234.
- Simultaneous `cpu_read`+`cpu_write` to addr 3 with 32'hCCCC → only write performed; requests pulsed while `cpu_busy`=1 ignored.
- Assert `reset` low during MEM_RD → enables drop same cycle, no `cpu_ready`; subsequent read of previously cached addr is a miss.
